conv_img_stripe_server: RTL and testbench

CONV_IMG_STRIPE_SERVER -- requirements
Module: conv_img_stripe_server

---
 rtl/conv_img_stripe_server.sv | 222 ++++++++++++++++++++++
 tb/tb_conv_img_stripe_server.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_img_stripe_server.sv
// Image stripe server: loads an IMG_W x IMG_H x IMG_D image into FILTER_W lanes per channel
// and serves it to a convolution engine. Define CONV_IMG_PINGPONG_EN for two alternating buffers.
module conv_img_stripe_server #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int IMG_D = 4,
  parameter int FILTER_W = 3,
  localparam int BANK_DEPTH = (IMG_W*IMG_H + FILTER_W - 1) / FILTER_W,
  localparam int BANK_ADDR_WIDTH = $clog2(BANK_DEPTH),
  localparam int NBANK = IMG_D*FILTER_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            pix_data,
  input  logic                             pix_val,
  output logic                             pix_rdy,
  output logic                             conv_val_in,
  input  logic                             conv_rdy_in,
  input  logic                             conv_done,
  input  logic [BANK_ADDR_WIDTH*NBANK-1:0] img_rdaddress,
  output logic [DATA_WIDTH*NBANK-1:0]      img_data_out,
  output logic                             serving
);
  localparam int NPIX = IMG_W*IMG_H;
  localparam int N_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int D_W = (IMG_D > 1) ? $clog2(IMG_D) : 1;
  localparam int L_W = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;
`ifdef CONV_IMG_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif
  localparam int IDX_W = (NBUF*BANK_DEPTH > 1) ? $clog2(NBUF*BANK_DEPTH) : 1;

  typedef enum logic [1:0] {LOAD, OFFER, SERVE} state_t;

  logic [N_W-1:0]             n_reg;
  logic [D_W-1:0]             d_reg;
  logic [L_W-1:0]             lane_reg;
  logic [BANK_ADDR_WIDTH-1:0] addr_reg;
  logic                       accept;
  logic                       last_n;
  logic                       last_pix;
  logic                       wr_buf;
  logic                       rd_buf;
  logic [IDX_W-1:0]           wr_idx;

  assign accept   = pix_val & pix_rdy;
  assign last_n   = (n_reg == N_W'(NPIX-1));
  assign last_pix = last_n & (d_reg == D_W'(IMG_D-1));

  // lane/addr track n mod FILTER_W and n / FILTER_W incrementally, avoiding a divider
  always_ff @(posedge clk) begin
    if (!reset) begin
      n_reg    <= '0;
      d_reg    <= '0;
      lane_reg <= '0;
      addr_reg <= '0;
    end else if (accept) begin
      if (last_n) begin
        n_reg    <= '0;
        lane_reg <= '0;
        addr_reg <= '0;
        d_reg    <= last_pix ? '0 : d_reg + 1'b1;
      end else begin
        n_reg <= n_reg + 1'b1;
        if (lane_reg == L_W'(FILTER_W-1)) begin
          lane_reg <= '0;
          addr_reg <= addr_reg + 1'b1;
        end else begin
          lane_reg <= lane_reg + 1'b1;
        end
      end
    end
  end

  assign wr_idx = wr_buf ? IDX_W'(BANK_DEPTH) + IDX_W'(addr_reg) : IDX_W'(addr_reg);

`ifdef CONV_IMG_PINGPONG_EN
  state_t bst_reg  [NBUF];
  state_t bst_next [NBUF];
  logic   wr_sel_reg, wr_sel_next;
  logic   offer_sel_reg, offer_sel_next;
  logic   rd_sel_reg, rd_sel_next;
  logic   any_serve_next;

  // Images complete and are offered in the same A/B order, so one pointer each suffices
  always_comb begin
    bst_next       = bst_reg;
    wr_sel_next    = wr_sel_reg;
    offer_sel_next = offer_sel_reg;
    rd_sel_next    = rd_sel_reg;
    if (accept && last_pix) begin
      bst_next[wr_sel_reg] = OFFER;
      wr_sel_next          = ~wr_sel_reg;
    end
    if (conv_val_in && conv_rdy_in) begin
      bst_next[offer_sel_reg] = SERVE;
      rd_sel_next             = offer_sel_reg;
      offer_sel_next          = ~offer_sel_reg;
    end
    if (conv_done) begin
      for (int i = 0; i < NBUF; i++) begin
        if (bst_reg[i] == SERVE) bst_next[i] = LOAD;
      end
    end
  end

  assign any_serve_next = (bst_next[0] == SERVE) || (bst_next[1] == SERVE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      bst_reg[0]    <= LOAD;
      bst_reg[1]    <= LOAD;
      wr_sel_reg    <= 1'b0;
      offer_sel_reg <= 1'b0;
      rd_sel_reg    <= 1'b0;
      pix_rdy       <= 1'b0;
      conv_val_in   <= 1'b0;
      serving       <= 1'b0;
    end else begin
      bst_reg       <= bst_next;
      wr_sel_reg    <= wr_sel_next;
      offer_sel_reg <= offer_sel_next;
      rd_sel_reg    <= rd_sel_next;
      pix_rdy       <= (bst_next[wr_sel_next] == LOAD);
      conv_val_in   <= (bst_next[offer_sel_next] == OFFER) && !any_serve_next;
      serving       <= any_serve_next;
    end
  end

  assign wr_buf = wr_sel_reg;
  assign rd_buf = rd_sel_reg;
`else
  state_t state_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= LOAD;
      pix_rdy     <= 1'b0;
      conv_val_in <= 1'b0;
      serving     <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (accept && last_pix) begin
            state_reg   <= OFFER;
            pix_rdy     <= 1'b0;
            conv_val_in <= 1'b1;
          end else begin
            pix_rdy <= 1'b1;
          end
        end
        OFFER: begin
          if (conv_rdy_in) begin
            state_reg   <= SERVE;
            conv_val_in <= 1'b0;
            serving     <= 1'b1;
          end
        end
        SERVE: begin
          if (conv_done) begin
            state_reg <= LOAD;
            serving   <= 1'b0;
            pix_rdy   <= 1'b1;
          end
        end
        default: begin
          state_reg   <= LOAD;
          pix_rdy     <= 1'b0;
          conv_val_in <= 1'b0;
          serving     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_buf = 1'b0;
  assign rd_buf = 1'b0;
`endif

  genvar gi, gl;
  generate
    for (gi = 0; gi < IMG_D; gi++) begin : g_chan
      for (gl = 0; gl < FILTER_W; gl++) begin : g_lane
        localparam int B = gi*FILTER_W + gl;
        // Locations past the last pixel of this lane are never written and must read as 0
        localparam logic [BANK_ADDR_WIDTH:0] LANE_DEPTH =
          (BANK_ADDR_WIDTH+1)'((NPIX - gl + FILTER_W - 1) / FILTER_W);

        logic [DATA_WIDTH-1:0]      mem [NBUF*BANK_DEPTH];
        logic [BANK_ADDR_WIDTH-1:0] raddr;
        logic [BANK_ADDR_WIDTH-1:0] raddr_safe;
        logic [IDX_W-1:0]           rd_idx;
        logic                       raddr_ok;
        logic                       ok_reg;
        logic                       we;
        logic [DATA_WIDTH-1:0]      rd_reg;

        assign raddr      = img_rdaddress[B*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
        assign raddr_ok   = ({1'b0, raddr} < LANE_DEPTH);
        assign raddr_safe = raddr_ok ? raddr : '0;
        assign rd_idx     = rd_buf ? IDX_W'(BANK_DEPTH) + IDX_W'(raddr_safe) : IDX_W'(raddr_safe);
        assign we         = accept && (d_reg == D_W'(gi)) && (lane_reg == L_W'(gl));

        always_ff @(posedge clk) begin
          if (we) mem[wr_idx] <= pix_data;
          rd_reg <= mem[rd_idx];
        end

        always_ff @(posedge clk) begin
          if (!reset) ok_reg <= 1'b0;
          else        ok_reg <= raddr_ok;
        end

        assign img_data_out[B*DATA_WIDTH +: DATA_WIDTH] = ok_reg ? rd_reg : '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_conv_img_stripe_server.sv
// Bench for conv_img_stripe_server: table-driven reads plus randomized loads/reads checked
// against an image-array model of the bank mapping.
module tb_conv_img_stripe_server;
  localparam int DW = 8;
  localparam int ID = 4;
  localparam int FW = 3;
  localparam int NPIX = 64;
  localparam int BD = 22;
  localparam int AW = 5;
  localparam int NB = ID*FW;
`ifdef CONV_IMG_PINGPONG_EN
  localparam int PP = 1;
`else
  localparam int PP = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_val = 1'b0;
  logic pix_rdy;
  logic conv_val_in;
  logic conv_rdy_in = 1'b0;
  logic conv_done = 1'b0;
  logic serving;
  logic [DW-1:0] pix_data = '0;
  logic [AW*NB-1:0] img_rdaddress = '0;
  logic [DW*NB-1:0] img_data_out;

  int tests = 0;
  int fails = 0;
  int img_model [ID][NPIX];

  typedef struct {
    int bank;
    int addr;
    int exp;
  } rd_vec_t;
  rd_vec_t vecs [10];

  always #5 clk = ~clk;

  conv_img_stripe_server #(
    .DATA_WIDTH(DW), .IMG_W(8), .IMG_H(8), .IMG_D(ID), .FILTER_W(FW)
  ) dut (
    .clk(clk), .reset(reset), .pix_data(pix_data), .pix_val(pix_val), .pix_rdy(pix_rdy),
    .conv_val_in(conv_val_in), .conv_rdy_in(conv_rdy_in), .conv_done(conv_done),
    .img_rdaddress(img_rdaddress), .img_data_out(img_data_out), .serving(serving)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected bank content from the storage rule: bank d*FW+lane, address n/FW
  function automatic int exp_field(input int b, input int a);
    int d;
    int lane;
    int n;
    d = b / FW;
    lane = b % FW;
    n = a*FW + lane;
    if (a >= BD || n >= NPIX) return 0;
    return img_model[d][n];
  endfunction

  function automatic int field(input int b);
    return int'(img_data_out[b*DW +: DW]);
  endfunction

  task automatic read_cycle(input int addrs [NB], input string tag);
    for (int b = 0; b < NB; b++) img_rdaddress[b*AW +: AW] = AW'(addrs[b]);
    tick;
    for (int b = 0; b < NB; b++)
      check($sformatf("%s_b%0d_a%0d", tag, b, addrs[b]), field(b), exp_field(b, addrs[b]));
    $display("[TB] read %s", tag);
  endtask

  task automatic load_image(input int count, input bit rnd_val, input bit gaps,
                            input bit rnd_done, input int exp_srv, input string tag);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < count) begin
      int d;
      int n;
      logic [7:0] v;
      d = k / NPIX;
      n = k % NPIX;
      pix_val = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      v = rnd_val ? 8'($urandom) : 8'((n + 64*d) % 256);
      pix_data = pix_val ? v : 8'($urandom);
      conv_done = rnd_done ? 1'($urandom_range(0, 1)) : 1'b0;
      check($sformatf("%s_pix_rdy_c%0d", tag, cyc), pix_rdy, 1);
      check($sformatf("%s_conv_val_c%0d", tag, cyc), conv_val_in, 0);
      check($sformatf("%s_serving_c%0d", tag, cyc), serving, exp_srv);
      if (pix_val) begin
        img_model[d][n] = v;
        k++;
      end
      tick;
      cyc++;
    end
    pix_val = 1'b0;
    conv_done = 1'b0;
    $display("[TB] load %s: %0d pixels in %0d cycles", tag, count, cyc);
  endtask

  task automatic readback_all(input string tag);
    int addrs [NB];
    for (int a = 0; a < BD; a++) begin
      for (int b = 0; b < NB; b++) addrs[b] = a;
      read_cycle(addrs, $sformatf("%s_a%0d", tag, a));
    end
  endtask

  initial begin
    int addrs [NB];
    vecs[0] = '{7, 5, 144};
    vecs[1] = '{2, 21, 0};
    vecs[2] = '{2, 30, 0};
    vecs[3] = '{0, 21, 63};
    vecs[4] = '{11, 20, 254};
    vecs[5] = '{1, 21, 0};
    vecs[6] = '{3, 0, 64};
    vecs[7] = '{5, 10, 96};
    vecs[8] = '{9, 21, 255};
    vecs[9] = '{10, 7, 214};

    // reset state
    tick;
    tick;
    check("rst_pix_rdy", pix_rdy, 0);
    check("rst_conv_val", conv_val_in, 0);
    check("rst_serving", serving, 0);
    check("rst_data_zero", (img_data_out == '0) ? 1 : 0, 1);
    reset = 1'b1;
    tick;
    check("release_pix_rdy", pix_rdy, 1);

    // conv_done while loading is ignored
    conv_done = 1'b1;
    tick;
    conv_done = 1'b0;
    check("load_done_pix_rdy", pix_rdy, 1);
    check("load_done_conv_val", conv_val_in, 0);
    check("load_done_serving", serving, 0);

    load_image(256, 1'b0, 1'b0, 1'b1, 0, "formula");
    check("offer_conv_val", conv_val_in, 1);
    check("offer_pix_rdy", pix_rdy, PP);
    check("offer_serving", serving, 0);

    // table-driven reads while the image is offered
    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < NB; b++) addrs[b] = $urandom_range(0, 31);
      addrs[vecs[i].bank] = vecs[i].addr;
      read_cycle(addrs, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_b%0d_a%0d", i, vecs[i].bank, vecs[i].addr),
            field(vecs[i].bank), vecs[i].exp);
    end

    // engine not ready: offer must hold
    for (int c = 0; c < 10; c++) begin
      tick;
      check($sformatf("hold_conv_val_c%0d", c), conv_val_in, 1);
      check($sformatf("hold_serving_c%0d", c), serving, 0);
    end
    conv_rdy_in = 1'b1;
    tick;
    conv_rdy_in = 1'b0;
    check("hs_serving", serving, 1);
    check("hs_conv_val", conv_val_in, 0);
    check("hs_pix_rdy", pix_rdy, PP);

    // reads while serving; offered pixels must not reach the bound buffer
    for (int c = 0; c < 20; c++) begin
`ifndef CONV_IMG_PINGPONG_EN
      pix_val = 1'($urandom_range(0, 1));
      pix_data = 8'($urandom);
`endif
      for (int b = 0; b < NB; b++) addrs[b] = $urandom_range(0, 31);
      read_cycle(addrs, $sformatf("serve_c%0d", c));
      check($sformatf("serve_pix_rdy_c%0d", c), pix_rdy, PP);
      check($sformatf("serve_serving_c%0d", c), serving, 1);
    end
    pix_val = 1'b0;

    conv_done = 1'b1;
    tick;
    conv_done = 1'b0;
    check("done_serving", serving, 0);
    check("done_pix_rdy", pix_rdy, 1);
    check("done_conv_val", conv_val_in, 0);

    // abandon a partial load with reset, then reload with random data
    load_image(100, 1'b1, 1'b1, 1'b1, 0, "partial");
    reset = 1'b0;
    tick;
    tick;
    check("midrst_pix_rdy", pix_rdy, 0);
    check("midrst_conv_val", conv_val_in, 0);
    check("midrst_serving", serving, 0);
    check("midrst_data_zero", (img_data_out == '0) ? 1 : 0, 1);
    reset = 1'b1;
    tick;
    check("midrst_release_pix_rdy", pix_rdy, 1);

    load_image(256, 1'b1, 1'b1, 1'b1, 0, "reload");
    check("reload_conv_val", conv_val_in, 1);
    conv_rdy_in = 1'b1;
    tick;
    conv_rdy_in = 1'b0;
    check("reload_serving", serving, 1);
    readback_all("reload");

`ifdef CONV_IMG_PINGPONG_EN
    // second image loads into the other buffer while the first is served
    load_image(256, 1'b1, 1'b1, 1'b0, 1, "pp_second");
    check("pp_full_conv_val", conv_val_in, 0);
    check("pp_full_pix_rdy", pix_rdy, 0);
    check("pp_full_serving", serving, 1);
    conv_done = 1'b1;
    tick;
    conv_done = 1'b0;
    check("pp_done_conv_val", conv_val_in, 1);
    check("pp_done_serving", serving, 0);
    check("pp_done_pix_rdy", pix_rdy, 1);
    conv_rdy_in = 1'b1;
    tick;
    conv_rdy_in = 1'b0;
    check("pp_hs_serving", serving, 1);
    readback_all("pp_second");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
